// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: load-use stalls,
// branch/jump redirect, EX forwarding selects, data-memory handshake freeze
// and saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_has_rs2,
    input  logic             id_without_rs,
    input  logic             ex_valid,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwrite,
    input  logic             ex_memread,
    input  logic [7:0]       ex_jump_type,
    input  logic             ex_taken,
    input  logic             mem_valid,
    input  logic [4:0]       mem_rd,
    input  logic             mem_regwrite,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic             wb_regwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       npc_sel,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned SEL_W = 2;
    localparam logic [SEL_W-1:0] SEL_RF  = 2'b00;
    localparam logic [SEL_W-1:0] SEL_MEM = 2'b10;
    localparam logic [SEL_W-1:0] SEL_WB  = 2'b01;
    localparam logic [SEL_W-1:0] NPC_SEQ = 2'b00;
    localparam logic [SEL_W-1:0] NPC_REL = 2'b01;
    localparam logic [SEL_W-1:0] NPC_JR  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    mem_state_t state_q;
    mem_state_t state_d;
    logic       acc;
    logic       req_c;
    logic       mem_stall;
    logic       lu;
    logic       redir;
    logic       lu_apply;
    logic       redir_apply;

    // ex_regwrite is carried for completeness; load-use keys off ex_memread.
    logic       unused_ex_regwrite;
    assign unused_ex_regwrite = ex_regwrite;

    assign acc = mem_valid & (mem_memread | mem_memwrite);

    // Hazard conditions before priority resolution
    assign lu = ex_valid & ex_memread & (ex_rd != 5'd0) & id_valid & ~id_without_rs
              & ((ex_rd == id_rs1) | (id_has_rs2 & (ex_rd == id_rs2)));
    assign redir = ex_valid & (ex_jump_type[6] | ex_jump_type[7]
                 | ((|ex_jump_type[5:0]) & ex_taken));

    // Memory handshake state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory handshake next state and raw request
    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        case (state_q)
            IDLE: begin
                req_c = acc;
                if (acc && !dmem_ready) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                req_c = 1'b1;
                if (dmem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Request is masked during reset so a mid-access reset drops it at once
    assign dmem_req    = req_c & ~rst;
    assign mem_stall   = dmem_req & ~dmem_ready;
    assign redir_apply = ~rst & redir & ~mem_stall;
    assign lu_apply    = ~rst & lu & ~mem_stall & ~redir;

    // Enables, flushes and next-PC select, priority mem_stall > redirect > load-use
    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;
        npc_sel      = NPC_SEQ;
        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            mem_wb_flush = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            if_id_en     = 1'b0;
            id_ex_en     = 1'b0;
            ex_mem_en    = 1'b0;
            mem_wb_flush = 1'b1;
        end else if (redir_apply) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            npc_sel     = ex_jump_type[7] ? NPC_JR : NPC_REL;
        end else if (lu_apply) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end
    end

    // Forwarding select for one EX source register, MEM result before WB result
    function automatic logic [SEL_W-1:0] fwd_sel(input logic [4:0] rs);
        if (mem_valid && mem_regwrite && !mem_memread && mem_rd != 5'd0 && mem_rd == rs) begin
            return SEL_MEM;
        end else if (wb_valid && wb_regwrite && wb_rd != 5'd0 && wb_rd == rs) begin
            return SEL_WB;
        end
        return SEL_RF;
    endfunction

    // Operand forwarding selects, forced to register file during reset
    always_comb begin
        fwd_a = SEL_RF;
        fwd_b = SEL_RF;
        if (!rst) begin
            fwd_a = fwd_sel(ex_rs1);
            fwd_b = fwd_sel(ex_rs2);
        end
    end

    // Saturating stall counter: memory freeze or applied load-use bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((mem_stall || lu_apply) && stall_cnt != CNT_MAX) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    // Saturating flush counter: applied redirects
    always_ff @(posedge clk) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (redir_apply && flush_cnt != CNT_MAX) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed table-driven bench for pipe_hazard_ctrl with hand-written
// sequences for memory wait, reset mid-access and counter saturation.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CNT_W = 16;
    localparam int unsigned NV    = 17;
    localparam int          SAT_N = (1 << CNT_W) + 3;

    typedef struct {
        logic       id_valid;
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_has_rs2;
        logic       id_without_rs;
        logic       ex_valid;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_regwrite;
        logic       ex_memread;
        logic [7:0] ex_jump_type;
        logic       ex_taken;
        logic       mem_valid;
        logic [4:0] mem_rd;
        logic       mem_regwrite;
        logic       mem_memread;
        logic       mem_memwrite;
        logic       wb_valid;
        logic [4:0] wb_rd;
        logic       wb_regwrite;
        logic       dmem_ready;
    } in_t;

    // en = {pc, if_id, id_ex, ex_mem}; fl = {if_id, id_ex, mem_wb}
    typedef struct {
        logic       req;
        logic [3:0] en;
        logic [2:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [1:0] npc;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    in_t  cur;
    logic dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en;
    logic if_id_flush, id_ex_flush, mem_wb_flush;
    logic [1:0] fwd_a, fwd_b, npc_sel;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    vec_t tbl [NV];

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(cur.id_valid), .id_rs1(cur.id_rs1), .id_rs2(cur.id_rs2),
        .id_has_rs2(cur.id_has_rs2), .id_without_rs(cur.id_without_rs),
        .ex_valid(cur.ex_valid), .ex_rs1(cur.ex_rs1), .ex_rs2(cur.ex_rs2),
        .ex_rd(cur.ex_rd), .ex_regwrite(cur.ex_regwrite), .ex_memread(cur.ex_memread),
        .ex_jump_type(cur.ex_jump_type), .ex_taken(cur.ex_taken),
        .mem_valid(cur.mem_valid), .mem_rd(cur.mem_rd), .mem_regwrite(cur.mem_regwrite),
        .mem_memread(cur.mem_memread), .mem_memwrite(cur.mem_memwrite),
        .wb_valid(cur.wb_valid), .wb_rd(cur.wb_rd), .wb_regwrite(cur.wb_regwrite),
        .dmem_ready(cur.dmem_ready), .dmem_req(dmem_req),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .npc_sel(npc_sel),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    function automatic in_t idle_in();
        in_t r;
        r = '{default: '0};
        r.dmem_ready = 1'b1;
        return r;
    endfunction

    function automatic out_t out_of(input logic req, input logic [3:0] en, input logic [2:0] fl,
                                    input logic [1:0] fa, input logic [1:0] fb, input logic [1:0] npc);
        out_t r;
        r.req = req; r.en = en; r.fl = fl; r.fa = fa; r.fb = fb; r.npc = npc;
        return r;
    endfunction

    // lw x5 in EX against an ID instruction reading rs1/rs2
    function automatic in_t lu_in(input logic [4:0] rs1, input logic [4:0] rs2,
                                  input logic has2, input logic wo, input logic [4:0] rd);
        in_t r;
        r = idle_in();
        r.ex_valid = 1'b1; r.ex_memread = 1'b1; r.ex_regwrite = 1'b1; r.ex_rd = rd;
        r.id_valid = 1'b1; r.id_rs1 = rs1; r.id_rs2 = rs2;
        r.id_has_rs2 = has2; r.id_without_rs = wo;
        return r;
    endfunction

    function automatic in_t br_in(input logic [7:0] jt, input logic taken);
        in_t r;
        r = idle_in();
        r.ex_valid = 1'b1; r.ex_jump_type = jt; r.ex_taken = taken;
        return r;
    endfunction

    function automatic in_t fwd_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] mrd,
                                   input logic mrd_ld, input logic [4:0] wrd);
        in_t r;
        r = idle_in();
        r.ex_valid = 1'b1; r.ex_rs1 = rs1; r.ex_rs2 = rs2;
        r.mem_valid = 1'b1; r.mem_regwrite = 1'b1; r.mem_rd = mrd; r.mem_memread = mrd_ld;
        r.wb_valid = 1'b1; r.wb_regwrite = 1'b1; r.wb_rd = wrd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Apply one cycle of inputs at negedge, check controls, then counters after the edge
    task automatic step(input string name, input in_t i, input out_t e);
        logic [13:0] act;
        @(negedge clk);
        cur = i;
        #1;
        act = {dmem_req, pc_en, if_id_en, id_ex_en, ex_mem_en,
               if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, npc_sel};
        check(name, 32'(act), 32'({e.req, e.en, e.fl, e.fa, e.fb, e.npc}));
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (!e.en[3] && exp_stall < (1 << CNT_W) - 1) exp_stall++;
            if (e.fl[2] && e.npc != 2'b00 && exp_flush < (1 << CNT_W) - 1) exp_flush++;
        end
        @(posedge clk);
        #1;
        check({name, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
        check({name, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    endtask

    out_t o_def, o_lu, o_br, o_jr, o_frz;
    in_t  t;

    initial begin
        o_def = out_of(1'b0, 4'b1111, 3'b000, 2'b00, 2'b00, 2'b00);
        o_lu  = out_of(1'b0, 4'b0011, 3'b010, 2'b00, 2'b00, 2'b00);
        o_br  = out_of(1'b0, 4'b1111, 3'b110, 2'b00, 2'b00, 2'b01);
        o_jr  = out_of(1'b0, 4'b1111, 3'b110, 2'b00, 2'b00, 2'b10);
        o_frz = out_of(1'b1, 4'b0000, 3'b001, 2'b00, 2'b00, 2'b00);

        tbl[0]  = '{idle_in(), o_def};
        tbl[1]  = '{lu_in(5'd5, 5'd1, 1'b1, 1'b0, 5'd5), o_lu};
        tbl[2]  = '{lu_in(5'd5, 5'd1, 1'b1, 1'b1, 5'd5), o_def};
        tbl[3]  = '{lu_in(5'd1, 5'd5, 1'b1, 1'b0, 5'd5), o_lu};
        tbl[4]  = '{lu_in(5'd1, 5'd5, 1'b0, 1'b0, 5'd5), o_def};
        tbl[5]  = '{lu_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0), o_def};
        tbl[6]  = '{fwd_in(5'd3, 5'd0, 5'd3, 1'b0, 5'd3), out_of(1'b0, 4'b1111, 3'b000, 2'b10, 2'b00, 2'b00)};
        tbl[7]  = '{fwd_in(5'd3, 5'd0, 5'd3, 1'b1, 5'd3), out_of(1'b1, 4'b1111, 3'b000, 2'b01, 2'b00, 2'b00)};
        tbl[8]  = '{fwd_in(5'd0, 5'd3, 5'd7, 1'b0, 5'd3), out_of(1'b0, 4'b1111, 3'b000, 2'b00, 2'b01, 2'b00)};
        tbl[9]  = '{fwd_in(5'd0, 5'd0, 5'd7, 1'b0, 5'd0), o_def};
        tbl[10] = '{br_in(8'h01, 1'b1), o_br};
        tbl[11] = '{br_in(8'h01, 1'b0), o_def};
        tbl[12] = '{br_in(8'h80, 1'b0), o_jr};
        tbl[13] = '{br_in(8'h40, 1'b0), o_br};
        tbl[14] = '{br_in(8'h20, 1'b1), o_br};
        t = lu_in(5'd5, 5'd1, 1'b1, 1'b0, 5'd5);
        t.ex_jump_type = 8'h01; t.ex_taken = 1'b1;
        tbl[15] = '{t, o_br};
        t = br_in(8'h40, 1'b0);
        t.ex_valid = 1'b0;
        tbl[16] = '{t, o_def};

        // Reset state
        cur = idle_in();
        rst = 1'b1;
        step("reset", idle_in(), out_of(1'b0, 4'b1111, 3'b111, 2'b00, 2'b00, 2'b00));
        rst = 1'b0;

        for (int k = 0; k < NV; k++) begin
            step($sformatf("vec%0d", k), tbl[k].i, tbl[k].o);
        end

        // sw in MEM waiting 3 cycles, with a jal in EX held off until release
        t = br_in(8'h40, 1'b0);
        t.mem_valid = 1'b1; t.mem_memwrite = 1'b1; t.dmem_ready = 1'b0;
        for (int k = 0; k < 3; k++) step($sformatf("memwait%0d", k), t, o_frz);
        t.dmem_ready = 1'b1;
        step("memrelease", t, out_of(1'b1, 4'b1111, 3'b110, 2'b00, 2'b00, 2'b01));
        step("memafter", idle_in(), o_def);

        // Single-cycle access does not stall and leaves the FSM idle
        t = idle_in();
        t.mem_valid = 1'b1; t.mem_memread = 1'b1;
        step("mem1cyc", t, out_of(1'b1, 4'b1111, 3'b000, 2'b00, 2'b00, 2'b00));
        step("mem1cyc_idle", idle_in(), o_def);

        // Reset while BUSY drops the request immediately and returns to IDLE
        t = fwd_in(5'd3, 5'd3, 5'd3, 1'b0, 5'd3);
        t.mem_memwrite = 1'b1; t.dmem_ready = 1'b0;
        step("busy0", t, out_of(1'b1, 4'b0000, 3'b001, 2'b10, 2'b10, 2'b00));
        step("busy1", t, out_of(1'b1, 4'b0000, 3'b001, 2'b10, 2'b10, 2'b00));
        rst = 1'b1;
        step("rst_busy", t, out_of(1'b0, 4'b1111, 3'b111, 2'b00, 2'b00, 2'b00));
        rst = 1'b0;
        t = idle_in();
        t.dmem_ready = 1'b0;
        step("post_rst_idle", t, o_def);

        // Saturate the stall counter with a persistent load-use
        @(negedge clk);
        cur = lu_in(5'd5, 5'd1, 1'b1, 1'b0, 5'd5);
        for (int k = 0; k < SAT_N; k++) @(posedge clk);
        #1;
        check("stall_sat", 32'(stall_cnt), 32'h0000_FFFF);
        check("flush_hold", 32'(flush_cnt), 32'(exp_flush));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage RV32I core. It sits beside the main decoder and uses that decoder's `has_rs2`, `without_rs`, `memread` and `jump_type` outputs, carried down the pipeline registers. From them it generates per-stage enable and flush controls, EX-stage forwarding selects and the next-PC select. It also owns the data-memory request/ready handshake, freezing the pipeline on multi-cycle accesses, and keeps saturating stall and flush counters.

## Interface
Parameters:
- `CNT_W`, default 16: width of the performance counters.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `id_valid`, `id_rs1[4:0]`, `id_rs2[4:0]`, `id_has_rs2`, `id_without_rs` in: ID-stage instruction and its decode flags.
- `ex_valid`, `ex_rs1[4:0]`, `ex_rs2[4:0]`, `ex_rd[4:0]`, `ex_regwrite`, `ex_memread` in: EX-stage instruction.
- `ex_jump_type[7:0]` in: decode bit map, one-hot or zero. Bits [0] beq, [1] bne, [2] bge, [3] blt, [4] bgeu, [5] bltu, [6] jal, [7] jalr.
- `ex_taken` in 1: branch condition result from the ALU.
- `mem_valid`, `mem_rd[4:0]`, `mem_regwrite`, `mem_memread`, `mem_memwrite` in: MEM-stage instruction.
- `wb_valid`, `wb_rd[4:0]`, `wb_regwrite` in: WB-stage instruction.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `dmem_req` out 1: data memory access request.
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` out 1 each: register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1 each: insert a bubble, clearing valid, at the next edge.
- `fwd_a[1:0]`, `fwd_b[1:0]` out: operand select. 00 = register file, 10 = MEM result, 01 = WB result.
- `npc_sel[1:0]` out: next-PC select. 00 = PC+4, 01 = PC+imm (branch/jal), 10 = jalr target.
- `stall_cnt[CNT_W-1:0]`, `flush_cnt[CNT_W-1:0]` out: saturating counters.

## Operation
- **Mem FSM**, states IDLE and BUSY. Let `acc = mem_valid & (mem_memread | mem_memwrite)`.
  - IDLE: `dmem_req = acc`. If `acc & ~dmem_ready`, go to BUSY.
  - BUSY: `dmem_req = 1`. If `dmem_ready`, go to IDLE.
  - The FSM never leaves BUSY without `dmem_ready`.
- **mem_stall** = `dmem_req & ~dmem_ready`. While asserted:
  - `pc_en`, `if_id_en`, `id_ex_en` and `ex_mem_en` are all 0.
  - `mem_wb_flush` = 1.
  - Load-use and redirect are suppressed; they are re-evaluated once the freeze lifts.
- **Load-use**, `lu` = `ex_valid & ex_memread & ex_rd!=0 & id_valid & ~id_without_rs & (ex_rd==id_rs1 | (id_has_rs2 & ex_rd==id_rs2))`. If `lu & ~mem_stall & ~redir`:
  - `pc_en = 0` and `if_id_en = 0`.
  - `id_ex_flush = 1`, giving one bubble.
- **Redirect**, `redir` = `ex_valid & (ex_jump_type[6] | ex_jump_type[7] | (|ex_jump_type[5:0] & ex_taken))`. If `redir & ~mem_stall`:
  - `if_id_flush = 1` and `id_ex_flush = 1`.
  - `npc_sel` = 10 if `ex_jump_type[7]`, else 01.
  - Otherwise `npc_sel` = 00.
- **Priority**: mem_stall > redirect > load-use. A redirect and a load-use in the same cycle give redirect only, with `pc_en` = 1.
- **Forwarding**, computed for `fwd_a` from `ex_rs1`; `fwd_b` is identical using `ex_rs2`:
  - 10 if `mem_valid & mem_regwrite & ~mem_memread & mem_rd!=0 & mem_rd==ex_rs1`.
  - Else 01 if `wb_valid & wb_regwrite & wb_rd!=0 & wb_rd==ex_rs1`.
  - Else 00.
  - MEM takes priority over WB.
- **Counters**:
  - `stall_cnt` increments on every cycle with mem_stall or an applied load-use stall.
  - `flush_cnt` increments on every applied redirect.
  - Both saturate at all-ones and never wrap.
- All enables default to 1 and all flushes default to 0 when no condition applies.

## Timing
- Control outputs are combinational from the current inputs and FSM state, with zero-cycle latency. The FSM state and counters are registered.
- Reset (synchronous, `rst` = 1 at the edge):
  - FSM goes to IDLE; counters go to 0.
  - While `rst` is high: `dmem_req` = 0, all enables = 1, all flushes = 1, `fwd_*` = 00, `npc_sel` = 00.
- Reset during BUSY: the FSM returns to IDLE and `dmem_req` drops in the same cycle.
- Single-cycle access (`dmem_ready` high with the request): no stall and the FSM stays in IDLE.
- N-cycle access: the freeze lasts exactly N-1 cycles. The pipeline advances on the cycle `dmem_ready` is asserted.
- Load-use costs exactly 1 bubble. On the following cycle the load is in MEM with `mem_memread` = 1, so there is no MEM forward, and the WB forward applies one cycle later.
- A taken branch costs 2 bubbles: the IF/ID and ID/EX contents are flushed.

## Test plan
- Load-use: `lw x5` in EX (`ex_rd` = 5, `ex_memread` = 1) and `add x6,x5,x1` in ID → one cycle of `pc_en` = 0, `if_id_en` = 0, `id_ex_flush` = 1, `stall_cnt` 0→1. Repeat with `id_without_rs` = 1 (lui) → no stall.
- Forwarding: `mem_rd` = `wb_rd` = `ex_rs1` = 3, both regwrite → `fwd_a` = 10. With `mem_memread` = 1 → `fwd_a` = 01. With `ex_rs2` = 0 and `wb_rd` = 0 → `fwd_b` = 00.
- Redirect: `ex_jump_type` = 0x01 (beq) with `ex_taken` = 1 → `npc_sel` = 01, IF/ID and ID/EX flush, `flush_cnt` +1. With `ex_taken` = 0 → no flush. With 0x80 (jalr) → `npc_sel` = 10.
- Memory wait: sw in MEM with `dmem_ready` low for 3 cycles → 3 freeze cycles with `mem_wb_flush` = 1, `dmem_req` held at 1, and a simultaneous EX redirect suppressed until the release cycle.
- Reset mid-BUSY: assert `rst` → next cycle FSM is IDLE, `dmem_req` = 0, counters are 0.
- Saturation: force 2^CNT_W+3 stall cycles → `stall_cnt` holds at 0xFFFF.
